mac_crossbar_engine: RTL and testbench
======================================

MAC_CROSSBAR_ENGINE -- requirements
Module: mac_crossbar_engine

Interface
REQ-001 The block SHALL have parameter IN_LANES, default 4: number of multiplier input lanes.
REQ-002 The block SHALL have parameter OUT_LANES, default 4: number of output accumulators.
REQ-003 The block SHALL have parameter DATA_W, default 16: signed operand width.
REQ-004 The block SHALL have parameter ACC_W, default 40: signed accumulator width, with ACC_W >= 2*DATA_W + clog2(IN_LANES).
REQ-005 The block SHALL have parameter LEN_W, default 10: width of the beat-count field.
REQ-006 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: starts a run, honoured only in IDLE.
REQ-009 The block SHALL have port len, input, LEN_W bits: beats per run, latched on start.
REQ-010 The block SHALL have port route_mask, input, OUT_LANES*IN_LANES bits: bit [o*IN_LANES+i] routes lane i to output o, latched on start.
REQ-011 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input beat handshake.
REQ-012 The block SHALL have ports multiplier_in and multiplicand_in, input, IN_LANES*DATA_W bits each: packed operands, lane i at [i*DATA_W +: DATA_W].
REQ-013 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-014 The block SHALL have port flatsumout, output, OUT_LANES*ACC_W bits: packed accumulator results.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port ovf, output, OUT_LANES bits: per-output sticky overflow flags.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN SHALL occur on start with len!=0; this clears the accumulators, ovf and the beat counter, and latches len and route_mask.
REQ-019 IDLE->DONE SHALL occur on start with len==0, presenting all-zero results.
REQ-020 in_ready SHALL be 1 only in RUN; a beat is accepted when in_valid && in_ready.
REQ-021 In RUN, the block SHALL enter DRAIN in the cycle after the len-th beat is accepted, and in_ready SHALL drop in that same cycle.
REQ-022 The pipeline SHALL be: cycle t accept; t+1 registered products, p_i = signed DATA_W x DATA_W -> 2*DATA_W; t+2 registered per-output masked sum of p_i, sign-extended to ACC_W; t+3 accumulator update.
REQ-023 DRAIN SHALL last exactly 2 cycles, then the FSM SHALL enter DONE.
REQ-024 In DONE, out_valid SHALL be 1 and flatsumout and ovf SHALL be held stable until out_ready; DONE->IDLE SHALL occur on out_valid && out_ready.
REQ-025 start asserted outside IDLE SHALL be ignored; route_mask and len changes outside IDLE SHALL have no effect.
REQ-026 An output whose mask row is all zero SHALL accumulate 0.
REQ-027 in_valid gaps in RUN SHALL stall only acceptance; the pipeline SHALL advance every cycle, with bubbles adding 0.
REQ-028 Without saturation, accumulators SHALL wrap modulo 2^ACC_W and ovf[o] SHALL set on signed overflow.

Reset
REQ-029 On Rst low, at any time including mid-run, the state SHALL be IDLE, all accumulators and pipeline registers 0, ovf 0, in_ready 0, out_valid 0, busy 0, and flatsumout 0.
REQ-030 The first start SHALL be honoured on the first rising edge after Rst deasserts.

Configuration
REQ-031 With macro MAC_SATURATE_EN defined, the accumulator SHALL clamp to max positive / max negative of ACC_W on overflow, and ovf[o] SHALL still set.
REQ-032 Without MAC_SATURATE_EN, the accumulator SHALL wrap per REQ-028, and no clamp logic SHALL be synthesised.

Structure
REQ-033 Shared package mac_pkg SHALL hold the FSM state typedef (2-bit encoding), the DRAIN_CYCLES=2 constant, and the saturation min/max helper constants.
REQ-034 One sub-module mac_lane SHALL implement a single output's masked sum, accumulator and overflow/saturation, instantiated OUT_LANES times.

Verification
REQ-035 Default parameters, all-ones mask, len=3, every lane 2*3 per beat -> out_valid 2 cycles after DRAIN entry, each sum = 72, ovf=0.
REQ-036 Identity mask (o routes only i=o), lane i operands (i+1, -1), len=1 -> sums -1, -2, -3, -4.
REQ-037 start with len=0 -> DONE the next cycle, all sums 0, in_ready never 1.
REQ-038 len=4 with in_valid toggling 1,0,1,0,... -> exactly 4 beats accepted, result matches the gapless run, extra start in RUN ignored.
REQ-039 ACC_W=32, DATA_W=16, operands 0x7FFF*0x7FFF on 4 lanes, len=2, all-ones mask -> MAC_SATURATE_EN: sum 0x7FFFFFFF, ovf=1; undefined: wrapped value, ovf=1.
REQ-040 Rst low during the 2nd DRAIN cycle -> next edge IDLE, outputs 0; new run len=1 -> correct fresh result.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared package for mac_crossbar_engine: FSM state encoding, drain length and
// saturation bound helpers. Optional feature macro: MAC_SATURATE_EN.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pipeline depth between the last accepted beat and the final accumulator write
  localparam int DRAIN_CYCLES = 2;

  // Saturation bounds are built at this width and truncated to ACC_W (ACC_W <= 64)
  localparam int SAT_MAX_W = 64;

  // Bit pattern of the largest positive value of a w-bit signed number
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
    return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
  endfunction

  // Bit pattern of the most negative value of a w-bit signed number
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
    return SAT_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One output of the crossbar: masked sum of the registered lane products,
// accumulator and sticky overflow. MAC_SATURATE_EN selects clamping instead
// of modulo wrap on overflow.
module mac_lane
  import mac_pkg::*;
#(
  parameter int IN_LANES = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         acc_en,
  input  logic [IN_LANES-1:0]          mask,
  input  logic [IN_LANES*2*DATA_W-1:0] products,
  output logic [ACC_W-1:0]             acc,
  output logic                         ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(IN_LANES);
  // One guard bit above the wider of accumulator and sum, so the true result
  // of acc + sum is always representable and overflow is a simple range test.
  localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
`endif

  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   sum_d;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [EXT_W-1:0]   wide;
  logic [EXT_W-ACC_W:0]      top_bits;
  logic                      ovf_now;
  logic [ACC_W-1:0]          acc_d;

  // Masked sum of this output's routed lanes; unrouted lanes contribute 0
  always_comb begin
    // NOTE: every variable driven here gets a value before any branch, otherwise a latch is inferred.
    sum_d = '0;
    prod  = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      prod = products[i*PROD_W +: PROD_W];
      if (mask[i]) sum_d = sum_d + SUM_W'(prod);
    end
  end

  // Exact next value, overflow detection and wrap/clamp selection
  always_comb begin
    wide     = EXT_W'($signed(acc)) + EXT_W'(sum_q);
    top_bits = wide[EXT_W-1:ACC_W-1];
    // Representable in ACC_W only when the bits above the sign bit all copy it
    ovf_now  = !((&top_bits) || !(|top_bits));
`ifdef MAC_SATURATE_EN
    if (ovf_now) acc_d = wide[EXT_W-1] ? ACC_MIN : ACC_MAX;
    else         acc_d = wide[ACC_W-1:0];
`else
    acc_d = wide[ACC_W-1:0];
`endif
  end

  // Sum register advances every cycle; accumulator and flag only while a run is live
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (!rst_n) begin
      sum_q <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      sum_q <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      sum_q <= sum_d;
      if (acc_en) begin
        acc <= acc_d;
        ovf <= ovf | ovf_now;
      end
    end
  end

endmodule

// File: rtl/mac_crossbar_engine.sv
// Multi-lane MAC with a routing crossbar: IN_LANES signed products are summed
// into OUT_LANES accumulators under a per-run route mask. Control is a
// IDLE/RUN/DRAIN/DONE FSM. Optional feature macro: MAC_SATURATE_EN.
module mac_crossbar_engine
  import mac_pkg::*;
#(
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int LEN_W     = 10
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          start,
  input  logic [LEN_W-1:0]              len,
  input  logic [OUT_LANES*IN_LANES-1:0] route_mask,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_LANES*DATA_W-1:0]    multiplier_in,
  input  logic [IN_LANES*DATA_W-1:0]    multiplicand_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_LANES*ACC_W-1:0]    flatsumout,
  output logic                          busy,
  output logic [OUT_LANES-1:0]          ovf
);

  localparam int PROD_W = 2 * DATA_W;

  state_t                        state_q, state_d;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              beat_cnt_q;
  logic [OUT_LANES*IN_LANES-1:0] mask_q;
  logic [1:0]                    drain_cnt_q;
  logic                          start_run;
  logic                          accept;
  logic                          last_beat;
  logic                          drain_last;
  logic                          acc_en;
  logic signed [PROD_W-1:0]      op_a, op_b;
  logic [IN_LANES*PROD_W-1:0]    prod_d, prod_q;

  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt_q == len_q - LEN_W'(1));
  assign drain_last = (drain_cnt_q == 2'(DRAIN_CYCLES - 1));
  assign acc_en     = (state_q == RUN) || (state_q == DRAIN);

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    start_run = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_run = 1'b1;
          state_d   = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch run parameters on start; count accepted beats and drain cycles
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      len_q       <= '0;
      mask_q      <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else if (start_run) begin
      len_q       <= len;
      mask_q      <= route_mask;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (accept)             beat_cnt_q  <= beat_cnt_q + LEN_W'(1);
      if (state_q == DRAIN)   drain_cnt_q <= drain_cnt_q + 2'd1;
    end
  end

  // Full-precision signed lane products
  always_comb begin
    prod_d = '0;
    op_a   = '0;
    op_b   = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      op_a = PROD_W'($signed(multiplier_in[i*DATA_W +: DATA_W]));
      op_b = PROD_W'($signed(multiplicand_in[i*DATA_W +: DATA_W]));
      prod_d[i*PROD_W +: PROD_W] = op_a * op_b;
    end
  end

  // Product register: a cycle without an accepted beat is a zero bubble
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)        prod_q <= '0;
    else if (accept) prod_q <= prod_d;
    else             prod_q <= '0;
  end

  for (genvar o = 0; o < OUT_LANES; o++) begin : g_lane
    mac_lane #(
      .IN_LANES (IN_LANES),
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk      (Clk),
      .rst_n    (Rst),
      .clear    (start_run),
      .acc_en   (acc_en),
      .mask     (mask_q[o*IN_LANES +: IN_LANES]),
      .products (prod_q),
      .acc      (flatsumout[o*ACC_W +: ACC_W]),
      .ovf      (ovf[o])
    );
  end

endmodule

// File: tb/tb_mac_crossbar_engine.sv
// Self-checking bench for mac_crossbar_engine. Two instances share stimulus:
// default parameters (ACC_W=40) and ACC_W=32 for the overflow cases.
// Expected results come from an integer reference model pushed to a scoreboard.
module tb_mac_crossbar_engine;

`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [159:0] s40;
    logic [3:0]   o40;
    logic [127:0] s32;
    logic [3:0]   o32;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   len = '0;
  logic [15:0]  route_mask = '0;
  logic         in_valid = 1'b0;
  logic [63:0]  multiplier_in = '0;
  logic [63:0]  multiplicand_in = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid, busy;
  logic [159:0] flatsumout;
  logic [3:0]   ovf;
  logic         in_ready32, out_valid32, busy32;
  logic [127:0] flat32;
  logic [3:0]   ovf32;

  int total = 0;
  int bad   = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  exp_t        sb[$];

  always #5 Clk = ~Clk;

  mac_crossbar_engine dut (
    .Clk(Clk), .Rst(Rst), .start(start), .len(len), .route_mask(route_mask),
    .in_valid(in_valid), .in_ready(in_ready), .multiplier_in(multiplier_in),
    .multiplicand_in(multiplicand_in), .out_valid(out_valid), .out_ready(out_ready),
    .flatsumout(flatsumout), .busy(busy), .ovf(ovf)
  );

  mac_crossbar_engine #(.ACC_W(32)) dut32 (
    .Clk(Clk), .Rst(Rst), .start(start), .len(len), .route_mask(route_mask),
    .in_valid(in_valid), .in_ready(in_ready32), .multiplier_in(multiplier_in),
    .multiplicand_in(multiplicand_in), .out_valid(out_valid32), .out_ready(out_ready),
    .flatsumout(flat32), .busy(busy32), .ovf(ovf32)
  );

  function automatic logic [63:0] splat(input logic [15:0] v);
    return {4{v}};
  endfunction

  // Integer reference: exact sums, then wrap or clamp to the accumulator width
  function automatic exp_t model_exp(input logic [15:0] mask, input int n);
    exp_t e;
    logic signed [127:0] acc, s, xa, xb, hi, lo, m;
    logic signed [15:0]  a16, b16;
    logic [63:0]         v;
    int                  aw;
    bit                  flag;
    e = '0;
    for (int w = 0; w < 2; w++) begin
      aw = (w == 0) ? 40 : 32;
      hi = (128'sd1 <<< (aw - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (aw - 1));
      m  = 128'sd1 <<< aw;
      for (int o = 0; o < 4; o++) begin
        acc  = '0;
        flag = 1'b0;
        for (int b = 0; b < n; b++) begin
          s = '0;
          for (int i = 0; i < 4; i++) begin
            if (mask[o*4+i]) begin
              a16 = qa[b][i*16 +: 16];
              b16 = qb[b][i*16 +: 16];
              xa  = a16;
              xb  = b16;
              s   = s + xa * xb;
            end
          end
          acc = acc + s;
          if (acc > hi || acc < lo) begin
            flag = 1'b1;
            if (SAT) acc = (acc > hi) ? hi : lo;
            else begin
              while (acc > hi) acc = acc - m;
              while (acc < lo) acc = acc + m;
            end
          end
        end
        v = acc[63:0];
        if (w == 0) begin
          e.s40[o*40 +: 40] = v[39:0];
          e.o40[o]          = flag;
        end else begin
          e.s32[o*32 +: 32] = v[31:0];
          e.o32[o]          = flag;
        end
      end
    end
    return e;
  endfunction

  // Run one job end to end; gaps=1 toggles in_valid and tries a start mid-run
  task automatic run_job(input string name, input logic [15:0] mask, input int n, input bit gaps);
    exp_t e;
    int   beats;
    int   slot;
    int   lat;
    sb.push_back(model_exp(mask, n));
    @(negedge Clk);
    start = 1'b1; len = 10'(n); route_mask = mask;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    if (n == 0) begin
      total++;
      if ({out_valid, in_ready} !== 2'b10) begin
        bad++; $display("FAIL %s len0_done: got out_valid,in_ready=%b want 10", name, {out_valid, in_ready});
      end
    end else begin
      beats = 0;
      slot  = 0;
      while (beats < n) begin
        if (!gaps || (slot % 2 == 0)) begin
          start = 1'b0; in_valid = 1'b1;
          multiplier_in = qa[beats]; multiplicand_in = qb[beats];
          total++;
          if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s in_ready_run beat %0d: got %b want 1", name, beats, in_ready);
          end
          beats++;
        end else begin
          in_valid = 1'b0; multiplier_in = '1; multiplicand_in = '1;
          start = 1'b1; len = 10'd7; route_mask = 16'h0000;
        end
        slot++;
        @(negedge Clk);
      end
      // First DRAIN cycle: junk offered with in_valid high must be refused
      start = 1'b0; in_valid = 1'b1; multiplier_in = splat(16'h1234); multiplicand_in = splat(16'h4321);
      total++;
      if ({in_ready, out_valid, busy} !== 3'b001) begin
        bad++; $display("FAIL %s drain_entry: got in_ready,out_valid,busy=%b want 001", name, {in_ready, out_valid, busy});
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge Clk);
        lat++;
      end
      in_valid = 1'b0;
      total++;
      if (lat !== 2) begin
        bad++; $display("FAIL %s done_latency: got %0d cycles want 2", name, lat);
      end
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (out_valid !== 1'b1 || out_valid32 !== 1'b1) begin
          bad++; $display("FAIL %s out_valid[%0d]: got %b%b want 11", name, k, out_valid, out_valid32);
        end
        total++;
        if (flatsumout !== e.s40) begin
          bad++; $display("FAIL %s sums40[%0d]: got %h want %h", name, k, flatsumout, e.s40);
        end
        total++;
        if (ovf !== e.o40) begin
          bad++; $display("FAIL %s ovf40[%0d]: got %b want %b", name, k, ovf, e.o40);
        end
        total++;
        if (flat32 !== e.s32) begin
          bad++; $display("FAIL %s sums32[%0d]: got %h want %h", name, k, flat32, e.s32);
        end
        total++;
        if (ovf32 !== e.o32) begin
          bad++; $display("FAIL %s ovf32[%0d]: got %b want %b", name, k, ovf32, e.o32);
        end
        // Second pass holds out_ready low for a cycle to prove the results stay put
        if (k == 0) @(negedge Clk);
      end
    end
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    total++;
    if ({busy, out_valid, busy32, out_valid32} !== 4'b0000) begin
      bad++; $display("FAIL %s back_to_idle: got %b want 0000", name, {busy, out_valid, busy32, out_valid32});
    end
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    total++;
    if ({busy, in_ready, out_valid, ovf} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, in_ready, out_valid, ovf});
    end
    total++;
    if (flatsumout !== '0 || flat32 !== '0) begin
      bad++; $display("FAIL reset_sums: got %h / %h want 0", flatsumout, flat32);
    end
    @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  task automatic test_all_ones;
    qa = {splat(16'd2), splat(16'd2), splat(16'd2)};
    qb = {splat(16'd3), splat(16'd3), splat(16'd3)};
    run_job("all_ones", 16'hFFFF, 3, 1'b0);
  endtask

  task automatic test_identity;
    qa = {{16'd4, 16'd3, 16'd2, 16'd1}};
    qb = {splat(16'hFFFF)};
    run_job("identity", 16'h8421, 1, 1'b0);
  endtask

  task automatic test_len_zero;
    qa = {};
    qb = {};
    run_job("len_zero", 16'hFFFF, 0, 1'b0);
  endtask

  task automatic test_gaps;
    qa = {};
    qb = {};
    for (int b = 0; b < 4; b++) begin
      qa.push_back({$urandom(), $urandom()});
      qb.push_back({$urandom(), $urandom()});
    end
    run_job("gapless", 16'h5A3C, 4, 1'b0);
    run_job("gapped", 16'h5A3C, 4, 1'b1);
  endtask

  task automatic test_overflow;
    qa = {splat(16'h7FFF), splat(16'h7FFF)};
    qb = {splat(16'h7FFF), splat(16'h7FFF)};
    run_job("ovf_pos", 16'hFFFF, 2, 1'b0);
    qa = {splat(16'h8000), splat(16'h8000)};
    run_job("ovf_neg", 16'hFFFF, 2, 1'b0);
  endtask

  task automatic test_reset_in_drain;
    @(negedge Clk);
    start = 1'b1; len = 10'd2; route_mask = 16'hFFFF;
    @(negedge Clk);
    start = 1'b0; in_valid = 1'b1;
    multiplier_in = splat(16'd5); multiplicand_in = splat(16'd5);
    @(negedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    // Second DRAIN cycle: the first beat has already landed in the accumulators
    Rst = 1'b0;
    #1;
    total++;
    if ({busy, in_ready, out_valid, ovf, busy32, ovf32} !== 12'b0) begin
      bad++; $display("FAIL drain_reset_ctrl: got %b want 0", {busy, in_ready, out_valid, ovf, busy32, ovf32});
    end
    total++;
    if (flatsumout !== '0 || flat32 !== '0) begin
      bad++; $display("FAIL drain_reset_sums: got %h / %h want 0", flatsumout, flat32);
    end
    @(posedge Clk);
    #1;
    total++;
    if ({busy, out_valid} !== 2'b00 || flatsumout !== '0) begin
      bad++; $display("FAIL drain_reset_idle: got %b %h want 00 0", {busy, out_valid}, flatsumout);
    end
    Rst = 1'b1;
    qa = {{16'd7, 16'hFFFD, 16'd9, 16'd2}};
    qb = {{16'd11, 16'd6, 16'hFFF8, 16'd100}};
    run_job("fresh_after_reset", 16'h137F, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_identity();
    test_len_zero();
    test_gaps();
    test_overflow();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
